// File: rtl/imm_decode_stage_pkg.sv
// Shared types for the ID-stage immediate path: immediate select, RV32 opcodes, stage state.
package imm_types;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } imm_stage_state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/imm_decode_stage_immgen.sv
// Combinational RV32 immediate generator; the opcode field is not needed, so only [31:7] enters.
module imm_decode_stage_immgen
  import imm_types::*;
(
  input  logic [31:7] instr,
  input  imm_sel_e    sel,
  output logic [31:0] imm
);

  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (sel)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// ID-stage slot: opcode decode + immgen feeding a 2-entry skid buffer towards EX.
// Optional IMM_DECODE_ILLEGAL_EN flags unrecognised opcodes instead of treating them as I-type.
module imm_decode_stage
  import imm_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_imm,
  output imm_sel_e        out_imm_sel,
  output logic            out_illegal
);

  imm_stage_state_e state, state_nxt;
  imm_sel_e         dec_sel;
  logic             dec_zero;
  logic             dec_illegal;
  logic [31:0]      gen_imm;
  logic [31:0]      new_imm;
  logic             accept, pop;
  logic             load_head_in, load_skid_in, load_head_skid;

  logic [31:0]      head_instr_p1, skid_instr_p1;
  logic [XLEN-1:0]  head_pc_p1, skid_pc_p1;
  logic [31:0]      head_imm_p1, skid_imm_p1;
  imm_sel_e         head_sel_p1, skid_sel_p1;
  logic             head_illegal_p1, skid_illegal_p1;

  // Stage p0: decode and immediate generation on the incoming word
  always_comb begin
    dec_sel     = IMM_I;
    dec_zero    = 1'b0;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: dec_sel = IMM_I;
      OP_STORE:        dec_sel = IMM_S;
      OP_BRANCH:       dec_sel = IMM_B;
      OP_LUI, OP_AUIPC: dec_sel = IMM_U;
      OP_JAL:          dec_sel = IMM_J;
      OP_REG:          dec_zero = 1'b1;
      default: begin
`ifdef IMM_DECODE_ILLEGAL_EN
        dec_illegal = 1'b1;
        dec_zero    = 1'b1;
`else
        dec_sel     = IMM_I;
`endif
      end
    endcase
  end

  imm_decode_stage_immgen u_immgen (
    .instr (in_instr[31:7]),
    .sel   (dec_sel),
    .imm   (gen_imm)
  );

  assign new_imm = dec_zero ? 32'd0 : gen_imm;

  // in_ready depends only on the state register, never on out_ready
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_head_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          load_head_in = 1'b1;
          state_nxt    = ST_HALF;
        end
        ST_HALF: begin
          if (accept && !pop) begin
            load_skid_in = 1'b1;
            state_nxt    = ST_FULL;
          end else if (accept && pop) begin
            load_head_in = 1'b1;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: if (pop) begin
          load_head_skid = 1'b1;
          state_nxt      = ST_HALF;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Stage p1: head and skid entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_instr_p1   <= '0;
      head_pc_p1      <= '0;
      head_imm_p1     <= '0;
      head_sel_p1     <= IMM_I;
      head_illegal_p1 <= 1'b0;
      skid_instr_p1   <= '0;
      skid_pc_p1      <= '0;
      skid_imm_p1     <= '0;
      skid_sel_p1     <= IMM_I;
      skid_illegal_p1 <= 1'b0;
    end else begin
      if (load_head_in) begin
        head_instr_p1   <= in_instr;
        head_pc_p1      <= in_pc;
        head_imm_p1     <= new_imm;
        head_sel_p1     <= dec_sel;
        head_illegal_p1 <= dec_illegal;
      end else if (load_head_skid) begin
        head_instr_p1   <= skid_instr_p1;
        head_pc_p1      <= skid_pc_p1;
        head_imm_p1     <= skid_imm_p1;
        head_sel_p1     <= skid_sel_p1;
        head_illegal_p1 <= skid_illegal_p1;
      end
      if (load_skid_in) begin
        skid_instr_p1   <= in_instr;
        skid_pc_p1      <= in_pc;
        skid_imm_p1     <= new_imm;
        skid_sel_p1     <= dec_sel;
        skid_illegal_p1 <= dec_illegal;
      end
    end
  end

  assign out_instr   = head_instr_p1;
  assign out_pc      = head_pc_p1;
  assign out_imm     = head_imm_p1;
  assign out_imm_sel = head_sel_p1;
  assign out_illegal = head_illegal_p1;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: driver predicts accepted entries, monitor checks pops.
module tb_imm_decode_stage;
  import imm_types::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_imm;
  imm_sel_e        out_imm_sel;
  logic            out_illegal;

  int checks = 0;
  int failures = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_sel_e    sel;
    logic        illegal;
  } exp_t;

  exp_t q[$];

  imm_decode_stage #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_imm_sel (out_imm_sel),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Reference: immediates computed as signed field values, not bit-slice concatenation.
  function automatic exp_t ref_model(logic [31:0] instr, logic [31:0] pc);
    exp_t e;
    logic [6:0] opc;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    int v;
    opc = instr[6:0];
    i12 = instr[31:20];
    s12 = {instr[31:25], instr[11:7]};
    b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    e.instr = instr;
    e.pc = pc;
    e.illegal = 1'b0;
    e.sel = IMM_I;
    v = i12;
    case (opc)
      7'h13, 7'h03, 7'h67, 7'h73: begin e.sel = IMM_I; v = i12; end
      7'h23: begin e.sel = IMM_S; v = s12; end
      7'h63: begin e.sel = IMM_B; v = b13; end
      7'h37, 7'h17: begin e.sel = IMM_U; v = int'(instr & 32'hFFFF_F000); end
      7'h6F: begin e.sel = IMM_J; v = j21; end
      7'h33: v = 0;
      default: begin
`ifdef IMM_DECODE_ILLEGAL_EN
        e.illegal = 1'b1;
        v = 0;
`else
        v = i12;
`endif
      end
    endcase
    e.imm = 32'(v);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    chk({tag, "_out_pc"}, 32'(out_pc), 32'd0);
    chk({tag, "_out_imm"}, out_imm, 32'd0);
    chk({tag, "_out_imm_sel"}, 32'(out_imm_sel), 32'(IMM_I));
    chk({tag, "_out_illegal"}, 32'(out_illegal), 32'd0);
  endtask

  // Inputs applied after one edge are sampled at the following edge; prediction happens mid-cycle.
  task automatic drive(bit v, logic [31:0] instr, bit ordy, bit fl = 1'b0);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc_ctr;
    pc_ctr    = pc_ctr + 32'd4;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(ref_model(in_instr, in_pc));
    end
  endtask

  // Monitor: at the falling edge, compare the head against the scoreboard when EX pops it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (!flush && out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("sb_instr", out_instr, e.instr);
          chk("sb_pc", 32'(out_pc), e.pc);
          chk("sb_imm", out_imm, e.imm);
          chk("sb_sel", 32'(out_imm_sel), 32'(e.sel));
          chk("sb_illegal", 32'(out_illegal), 32'(e.illegal));
        end
      end
    end
  end

  logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

  initial begin
    logic [31:0] w;
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    drive(1, 32'hFFF0_0093, 1);
    drive(0, 32'h0, 1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_sel", 32'(out_imm_sel), 32'(IMM_I));
    chk("addi_illegal", 32'(out_illegal), 32'd0);

    drive(1, 32'hFE20_AE23, 1);
    drive(1, 32'h1234_52B7, 1);
    chk("sw_imm", out_imm, 32'hFFFF_FFFC);
    chk("sw_sel", 32'(out_imm_sel), 32'(IMM_S));
    drive(0, 32'h0, 1);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_sel", 32'(out_imm_sel), 32'(IMM_U));
    drive(0, 32'h0, 1);

    drive(1, 32'hFF9F_F06F, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 0);
      chk("jal_hold_imm", out_imm, 32'hFFFF_FFF8);
      chk("jal_hold_sel", 32'(out_imm_sel), 32'(IMM_J));
    end
    drive(0, 32'h0, 1);
    drive(0, 32'h0, 1);

    drive(1, 32'h0010_0113, 0);
    drive(1, 32'h0020_0193, 0);
    drive(1, 32'h0030_0213, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1, 32'h0030_0213, 0);
    drive(1, 32'h0030_0213, 1);
    drive(1, 32'h0030_0213, 1);
    drive(0, 32'h0, 1);
    drive(0, 32'h0, 1);
    drive(0, 32'h0, 1);

    drive(1, 32'h0040_0293, 0);
    drive(1, 32'h0050_0313, 0);
    drive(1, 32'h0060_0393, 0, 1);
    drive(0, 32'h0, 1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(0, 32'h0, 1);

    drive(1, 32'h0000_007F, 1);
    drive(0, 32'h0, 1);
`ifdef IMM_DECODE_ILLEGAL_EN
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_imm", out_imm, 32'd0);
`else
    chk("illegal_flag", 32'(out_illegal), 32'd0);
`endif
    drive(0, 32'h0, 1);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 10)];
      drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0);
      if (i == 200) begin
        drive(1, 32'h0070_0413, 0);
        drive(1, 32'h0080_0493, 0);
        drive(0, 32'h0, 0);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    drive(0, 32'h0, 1);
    drive(0, 32'h0, 1);
    drive(0, 32'h0, 1);
    drive(0, 32'h0, 1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
